// File: rtl/axis_flit_deserializer.sv
// Reassembles SERIALIZATION_FACTOR narrow flits into one wide AXIS beat and queues it in a small output FIFO.
// Optional per-flit tdest consistency check: define AXIS_DESER_DEST_CHECK_EN.
module axis_flit_deserializer #(
  parameter int TDATA_WIDTH          = 512,
  parameter int TDEST_WIDTH          = 4,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int OUT_BUFFER_DEPTH     = 4,
  localparam int FLIT_WIDTH          = TDATA_WIDTH / SERIALIZATION_FACTOR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [FLIT_WIDTH-1:0]  s_tdata,
  input  logic [TDEST_WIDTH-1:0] s_tdest,
  input  logic                   s_tlast,
  input  logic                   s_tend,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic [TDEST_WIDTH-1:0] m_tdest,
  output logic                   m_tlast,
  output logic                   err_framing,
  output logic                   err_dest,
  input  logic                   err_clr
);
  localparam int IDX_W = $clog2(SERIALIZATION_FACTOR);
  localparam int PTR_W = $clog2(OUT_BUFFER_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SERIALIZATION_FACTOR - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_BUFFER_DEPTH);

  typedef struct packed {
    logic [TDATA_WIDTH-1:0] data;
    logic [TDEST_WIDTH-1:0] dest;
    logic                   last;
  } beat_t;

  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [TDATA_WIDTH-1:0] asm_data;
  logic [TDEST_WIDTH-1:0] asm_dest;
  logic                   flit_ok, push, pop, frame_set, dest_set, dest_bad_now;
  beat_t                  push_beat, head;
  beat_t                  mem [OUT_BUFFER_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;

  // Ready depends only on registered state, so m_tready never reaches s_tready.
  assign s_tready = !rst && (idx != LAST_IDX || count < FULL_CNT);
  assign flit_ok  = s_tvalid && s_tready;

`ifdef AXIS_DESER_DEST_CHECK_EN
  logic dest_bad;
  assign dest_bad_now = dest_bad || (s_tdest != asm_dest);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          dest_bad <= 1'b0;
    else if (flit_ok) dest_bad <= (idx == '0) ? 1'b0 : dest_bad_now;
  end
`else
  assign dest_bad_now = 1'b0;
`endif

  always_comb begin
    idx_nxt   = idx;
    push      = 1'b0;
    frame_set = 1'b0;
    dest_set  = 1'b0;
    if (flit_ok) begin
      if (idx != LAST_IDX) begin
        if (s_tend) begin
          frame_set = 1'b1;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end else begin
        idx_nxt = '0;
        if (!s_tend)           frame_set = 1'b1;
        else if (dest_bad_now) dest_set  = 1'b1;
        else                   push      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      asm_data <= '0;
      asm_dest <= '0;
    end else begin
      idx <= idx_nxt;
      if (flit_ok) begin
        asm_data[int'(idx)*FLIT_WIDTH +: FLIT_WIDTH] <= s_tdata;
        if (idx == '0) asm_dest <= s_tdest;
      end
    end
  end

  // The end flit bypasses the assembly register so the beat is pushed on its own cycle.
  always_comb begin
    push_beat.data = asm_data;
    push_beat.data[(SERIALIZATION_FACTOR-1)*FLIT_WIDTH +: FLIT_WIDTH] = s_tdata;
    push_beat.dest = asm_dest;
    push_beat.last = s_tlast;
  end

  assign m_tvalid = (count != '0);
  assign pop      = m_tvalid && m_tready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_beat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Gate the head so outputs read as zero while empty (memory itself is not reset).
  assign head    = m_tvalid ? mem[rd_ptr] : '0;
  assign m_tdata = head.data;
  assign m_tdest = head.dest;
  assign m_tlast = head.last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_framing <= 1'b0;
      err_dest    <= 1'b0;
    end else begin
      if (frame_set)    err_framing <= 1'b1;
      else if (err_clr) err_framing <= 1'b0;
      if (dest_set)     err_dest    <= 1'b1;
      else if (err_clr) err_dest    <= 1'b0;
    end
  end
endmodule

// File: doc/axis_flit_deserializer.md
Name: axis_flit_deserializer

Overview:
- Receive end of the NoC serdes path: accepts the narrow flit stream that the serializer produces, SERIALIZATION_FACTOR flits per user beat.
- Reassembles each group of flits into one wide AXI-Stream beat (tdata/tdest/tlast) for the user side.
- Buffers reassembled beats in a small output FIFO, so the user's tready never combinationally reaches the flit-side ready.
- Single clock domain; sits between a router ejection port and the user AXIS output.

Parameters:
- TDATA_WIDTH, 512: wide user data width. Must be divisible by SERIALIZATION_FACTOR.
- TDEST_WIDTH, 4: destination field width.
- SERIALIZATION_FACTOR, 4: flits per wide beat. Must be ≥2.
- OUT_BUFFER_DEPTH, 4: wide-beat FIFO depth. Must be a power of 2 and ≥2.
- Derived: FLIT_WIDTH = TDATA_WIDTH/SERIALIZATION_FACTOR; IDX_W = $clog2(SERIALIZATION_FACTOR).

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous reset, active-high
- s_tvalid  in  1  flit valid
- s_tready  out  1  flit ready
- s_tdata  in  FLIT_WIDTH  flit payload slice
- s_tdest  in  TDEST_WIDTH  destination, replicated on every flit of a beat
- s_tlast  in  1  wide-beat tlast; meaningful on the end flit only
- s_tend  in  1  marks the final flit of a wide beat
- m_tvalid  out  1  wide beat valid
- m_tready  in  1  wide beat ready
- m_tdata  out  TDATA_WIDTH  reassembled data
- m_tdest  out  TDEST_WIDTH  destination
- m_tlast  out  1  packet last
- err_framing  out  1  sticky framing error
- err_dest  out  1  sticky tdest-mismatch error (see Optional Feature)
- err_clr  in  1  synchronous clear of both sticky error bits

Behaviour:
- Reset (rst=1, asynchronous):
  - idx=0; assembly register cleared; FIFO empty.
  - m_tvalid=0, m_tdata=0, m_tdest=0, m_tlast=0.
  - err_framing=0, err_dest=0.
  - s_tready forced 0 while rst is high.
- Flit transfer: occurs on s_tvalid&&s_tready. Flit k (k=idx) is written into tdata bits [k*FLIT_WIDTH +: FLIT_WIDTH]; flit 0 is the least-significant slice.
- tdest is captured from flit 0; tlast is captured from the end flit.
- Assembly state machine:
  - COLLECT (idx < SF-1):
    - Flit with s_tend=0 → idx+1.
    - Flit with s_tend=1 → framing error: set err_framing, discard the partial beat, idx=0, no push.
  - FINAL (idx == SF-1):
    - Flit with s_tend=1 → push {data, tdest, tlast} to the FIFO; idx=0.
    - Flit with s_tend=0 → framing error: set err_framing, discard the beat, idx=0.
- s_tready = !rst && (idx != SF-1 || fifo_count < OUT_BUFFER_DEPTH).
  - fifo_count is the registered count, so there is no m_tready→s_tready path.
  - Full FIFO plus a pop in the same cycle still gives s_tready=0 that cycle; the accept happens the following cycle.
- Latency: end flit accepted at cycle N with the FIFO empty → m_tvalid=1 at N+1. Back-to-back flits give full throughput of one wide beat per SF cycles.
- Output FIFO:
  - Standard AXIS: m_tvalid=!empty; m_t* held stable while m_tvalid && !m_tready.
  - Pointers wrap modulo OUT_BUFFER_DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
- Error bits: set on the cycle after the offending flit. err_clr clears them; if a set event and err_clr coincide, the set wins.
- Reset mid-beat: the partial beat and all buffered beats are lost. After reset, the first flit is treated as flit 0.

Optional Feature:
- Macro: AXIS_DESER_DEST_CHECK_EN
- Defined:
  - Every flit's s_tdest is compared against the captured flit-0 tdest.
  - Any mismatch in a beat sets err_dest and discards the whole beat on its end flit (no push). idx is still advanced/reset normally.
- Undefined: no comparison; s_tdest of flits 1..SF-1 is ignored; err_dest is tied to 0.

Test Plan:
- Single beat: 4 flits with data 0x11,0x22,0x33,0x44 (slice values), tdest=4'h1, s_tend only on flit 3, s_tlast=1 → one m beat, data = {0x44,0x33,0x22,0x11} slices, tdest=1, tlast=1, m_tvalid at end-flit cycle +1.
- Back-pressure: m_tready=0, send 5 beats → 4 stored. s_tready drops while idx=3 for the 5th beat. Raise m_tready → the 5th end flit is accepted one cycle after the first pop; all 5 beats emerge in order, each held stable while stalled.
- Framing short: s_tend on flit 1 → err_framing=1, no output. The next well-formed beat is delivered correctly. err_clr → err_framing=0.
- Framing long: no s_tend on flit 3 → err_framing=1, beat dropped, idx=0.
- Reset mid-beat: rst pulse after flit 2 with 2 beats queued → m_tvalid=0 immediately, FIFO empty. The following full beat is reassembled from flit 0.
- With AXIS_DESER_DEST_CHECK_EN: flit 2 carries tdest=4'h3 vs 4'h1 → err_dest=1, beat dropped. Without the macro: the same stimulus delivers the beat with tdest=1 and err_dest=0.
